// File: rtl/spi_text_pkg.sv
// Shared constants for the SPI text receiver and the framebuffer that consumes its bytes.
// The framebuffer imports DONE_HIST_W and SPI_DATA_W from here.
package spi_text_pkg;

    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 3;
    localparam int DONE_HIST_W     = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input. The whole chain is exposed so the
// caller can edge-detect on its last two stages.
module sync_ff #(
    parameter int   STAGES  = 3,
    parameter logic RST_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d,
    output logic [STAGES-1:0] q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_reg <= {STAGES{RST_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg;

endmodule

// File: rtl/spi_text_rx.sv
// Mode-0 SPI slave feeding the framebuffer text RAM: assembles MSB-first bytes, publishes
// them with a done-history strobe, echoes the previous byte on MISO and flags cut-short frames.
module spi_text_rx
    import spi_text_pkg::*;
#(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES,
    parameter int DATA_W      = SPI_DATA_W,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spi_sck,
    input  logic                   spi_mosi,
    input  logic                   spi_cs_n,
    output logic                   spi_miso,
    output logic [DATA_W-1:0]      spi_shift_reg,
    output logic [DONE_HIST_W-1:0] spi_done,
    output logic [CNT_W-1:0]       byte_count,
    output logic                   frame_err
);

    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam int               NEW      = SYNC_STAGES - 2;
    localparam int               OLD      = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] cs_q;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .d     (spi_sck),
        .q     (sck_q)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .d     (spi_mosi),
        .q     (mosi_q)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .d     (spi_cs_n),
        .q     (cs_q)
    );

    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;
    logic mosi_bit;

    assign sck_rise = sck_q[NEW] & ~sck_q[OLD];
    assign sck_fall = ~sck_q[NEW] & sck_q[OLD];
    assign cs_rise  = cs_q[NEW] & ~cs_q[OLD];
    assign cs_fall  = ~cs_q[NEW] & cs_q[OLD];
    assign mosi_bit = mosi_q[NEW];

    // fill_reg marks when cs_q[NEW] holds a real pin sample rather than the reset preset,
    // so a CS that is already low at reset release never looks like a fresh select.
    logic [SYNC_STAGES-1:0] fill_reg;
    logic                   pin_valid;
    logic                   armed_reg, armed_next;

    assign pin_valid = fill_reg[NEW];

    spi_state_t             state_reg, state_next;
    logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0]      rx_reg, rx_next;
    logic [DATA_W-1:0]      tx_reg, tx_next;
    logic                   tx_fresh_reg, tx_fresh_next;
    logic [DATA_W-1:0]      byte_reg, byte_next;
    logic                   done_reg, done_next;
    logic [DONE_HIST_W-1:0] hist_reg;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic                   ferr_reg, ferr_next;
    logic                   miso_reg, miso_next;
    logic [DATA_W-1:0]      rx_word;

    assign rx_word = {rx_reg[DATA_W-2:0], mosi_bit};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_reg     <= '0;
            armed_reg    <= 1'b0;
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            rx_reg       <= '0;
            tx_reg       <= '0;
            tx_fresh_reg <= 1'b0;
            byte_reg     <= '0;
            done_reg     <= 1'b0;
            hist_reg     <= '0;
            count_reg    <= '0;
            ferr_reg     <= 1'b0;
            miso_reg     <= 1'b0;
        end else begin
            fill_reg     <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
            armed_reg    <= armed_next;
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            rx_reg       <= rx_next;
            tx_reg       <= tx_next;
            tx_fresh_reg <= tx_fresh_next;
            byte_reg     <= byte_next;
            done_reg     <= done_next;
            hist_reg     <= {hist_reg[DONE_HIST_W-2:0], done_reg};
            count_reg    <= count_next;
            ferr_reg     <= ferr_next;
            miso_reg     <= miso_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        rx_next       = rx_reg;
        tx_next       = tx_reg;
        tx_fresh_next = tx_fresh_reg;
        byte_next     = byte_reg;
        done_next     = done_reg;
        count_next    = count_reg;
        ferr_next     = 1'b0;
        miso_next     = miso_reg;
        armed_next    = armed_reg | (pin_valid & cs_q[NEW]);

        case (state_reg)
            ST_IDLE: begin
                bit_cnt_next = '0;
                miso_next    = 1'b0;
                if (cs_fall && armed_reg) begin
                    state_next    = ST_ACTIVE;
                    tx_next       = byte_reg;
                    tx_fresh_next = 1'b0;
                    miso_next     = byte_reg[DATA_W-1];
                end
            end

            ST_ACTIVE: begin
                if (cs_rise) begin
                    // Deselect beats any SCK edge landing in the same cycle.
                    state_next   = ST_IDLE;
                    bit_cnt_next = '0;
                    miso_next    = 1'b0;
                    if (bit_cnt_reg != '0) begin
                        ferr_next = 1'b1;
                    end else begin
                        done_next = 1'b0;
                    end
                end else begin
                    if (sck_rise) begin
                        rx_next = rx_word;
                        if (bit_cnt_reg == '0) begin
                            done_next = 1'b0;
                        end
                        if (bit_cnt_reg == LAST_BIT) begin
                            byte_next     = rx_word;
                            done_next     = 1'b1;
                            count_next    = count_reg + 1'b1;
                            bit_cnt_next  = '0;
                            tx_next       = rx_word;
                            tx_fresh_next = 1'b1;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        // A freshly loaded echo byte has not had its MSB driven yet.
                        if (tx_fresh_reg) begin
                            miso_next     = tx_reg[DATA_W-1];
                            tx_fresh_next = 1'b0;
                        end else begin
                            tx_next   = {tx_reg[DATA_W-2:0], 1'b0};
                            miso_next = tx_reg[DATA_W-2];
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    logic unused_sync;
    assign unused_sync = ^{sck_q, mosi_q, cs_q, fill_reg};

    assign spi_miso      = miso_reg;
    assign spi_shift_reg = byte_reg;
    assign spi_done      = hist_reg;
    assign byte_count    = count_reg;
    assign frame_err     = ferr_reg;

endmodule

// File: tb/tb_spi_text_rx.sv
// Bench for spi_text_rx: a bit-banged SPI host at f_clk/16 against a byte-level reference
// model (expected byte queue, modular byte count, previous-byte echo).
module tb_spi_text_rx;

    localparam int CNT_W = 4;
    localparam int HALF  = 8;
    localparam int MAXB  = 32;

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic             spi_sck  = 1'b0;
    logic             spi_mosi = 1'b0;
    logic             spi_cs_n = 1'b1;
    logic             spi_miso;
    logic [7:0]       spi_shift_reg;
    logic [2:0]       spi_done;
    logic [CNT_W-1:0] byte_count;
    logic             frame_err;

    always #5 clk = ~clk;

    spi_text_rx #(
        .SYNC_STAGES (3),
        .DATA_W      (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .spi_cs_n      (spi_cs_n),
        .spi_miso      (spi_miso),
        .spi_shift_reg (spi_shift_reg),
        .spi_done      (spi_done),
        .byte_count    (byte_count),
        .frame_err     (frame_err)
    );

    int         passed = 0;
    int         total  = 0;
    int         exp_count;
    logic [7:0] exp_last;
    logic [7:0] tx_bytes   [MAXB];
    logic [7:0] echo_bytes [MAXB];
    int         tx_len;

    // Observations: byte visible on each framebuffer write strobe, spi_done changes, error pulses.
    logic [7:0] obs_q    [$];
    logic [2:0] done_seq [$];
    logic [2:0] done_prev = 3'b000;
    int         ferr_pulses = 0;
    int         ferr_long   = 0;
    logic       ferr_prev   = 1'b0;

    always @(negedge clk) begin
        if (spi_done !== done_prev) begin
            done_seq.push_back(spi_done);
            done_prev = spi_done;
        end
        if (spi_done[2:1] == 2'b01) obs_q.push_back(spi_shift_reg);
        if (frame_err === 1'b1) begin
            ferr_pulses++;
            if (ferr_prev) ferr_long++;
        end
        ferr_prev = frame_err;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        exp_count   = 0;
        exp_last    = 8'h00;
        obs_q.delete();
        done_seq.delete();
        ferr_pulses = 0;
        ferr_long   = 0;
    endtask

    task automatic cs_start();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Sends the top n bits of b MSB first; echo collects MISO as a mode-0 host samples it.
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] echo);
        echo = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            spi_mosi = b[7-i];
            repeat (HALF) @(negedge clk);
            echo[7-i] = spi_miso;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_frame();
        cs_start();
        for (int k = 0; k < tx_len; k++) send_bits(tx_bytes[k], 8, echo_bytes[k]);
        cs_end();
    endtask

    task automatic test_reset();
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        apply_reset();
        total++; if (spi_shift_reg !== 8'h00) $display("FAIL reset_shift: got %h want 00", spi_shift_reg); else passed++;
        total++; if (spi_done !== 3'b000) $display("FAIL reset_done: got %b want 000", spi_done); else passed++;
        total++; if (byte_count !== '0) $display("FAIL reset_count: got %0d want 0", byte_count); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else passed++;
        total++; if (spi_miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", spi_miso); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_single_byte();
        logic [7:0] got;
        logic [2:0] seq_got;
        logic [2:0] seq_exp [3];
        seq_exp[0] = 3'b001; seq_exp[1] = 3'b011; seq_exp[2] = 3'b111;
        apply_reset();
        tx_bytes[0] = 8'h41;
        tx_len      = 1;
        send_frame();
        got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        total++; if (obs_q.size() != 1) $display("FAIL single_events: got %0d want 1", obs_q.size()); else passed++;
        total++; if (got !== 8'h41) $display("FAIL single_byte: got %h want 41", got); else passed++;
        total++; if (spi_shift_reg !== 8'h41) $display("FAIL single_shift: got %h want 41", spi_shift_reg); else passed++;
        total++; if (byte_count !== CNT_W'(1)) $display("FAIL single_count: got %0d want 1", byte_count); else passed++;
        total++; if (ferr_pulses != 0) $display("FAIL single_ferr: got %0d want 0", ferr_pulses); else passed++;
        total++; if (echo_bytes[0] !== 8'h00) $display("FAIL single_echo: got %h want 00", echo_bytes[0]); else passed++;
        for (int i = 0; i < 3; i++) begin
            seq_got = (done_seq.size() > i) ? done_seq[i] : 3'bxxx;
            total++;
            if (seq_got !== seq_exp[i]) $display("FAIL single_done_seq%0d: got %b want %b", i, seq_got, seq_exp[i]);
            else passed++;
        end
        exp_count = 1;
        exp_last  = 8'h41;
        $display("test_single_byte: tx 41 rx %h count %0d", got, byte_count);
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] exp_echo;
        apply_reset();
        tx_bytes[0] = 8'h48; tx_bytes[1] = 8'h49; tx_bytes[2] = 8'h21;
        tx_len = 3;
        send_frame();
        total++; if (obs_q.size() != 3) $display("FAIL b2b_events: got %0d want 3", obs_q.size()); else passed++;
        for (int k = 0; k < tx_len; k++) begin
            got      = (obs_q.size() > k) ? obs_q[k] : 8'hxx;
            exp_echo = (k == 0) ? exp_last : tx_bytes[k-1];
            total++; if (got !== tx_bytes[k]) $display("FAIL b2b_byte%0d: got %h want %h", k, got, tx_bytes[k]); else passed++;
            total++; if (echo_bytes[k] !== exp_echo) $display("FAIL b2b_echo%0d: got %h want %h", k, echo_bytes[k], exp_echo); else passed++;
            $display("test_back_to_back: byte %0d tx %h rx %h miso %h", k, tx_bytes[k], got, echo_bytes[k]);
        end
        exp_count = 3;
        exp_last  = 8'h21;
        total++; if (byte_count !== CNT_W'(exp_count)) $display("FAIL b2b_count: got %0d want %0d", byte_count, exp_count); else passed++;
        total++; if (ferr_pulses != 0) $display("FAIL b2b_ferr: got %0d want 0", ferr_pulses); else passed++;
    endtask

    task automatic test_truncated();
        logic [7:0] got;
        obs_q.delete();
        ferr_pulses = 0;
        ferr_long   = 0;
        cs_start();
        send_bits(8'hFF, 5, echo_bytes[0]);
        cs_end();
        total++; if (ferr_pulses != 1) $display("FAIL trunc_ferr: got %0d pulses want 1", ferr_pulses); else passed++;
        total++; if (ferr_long != 0) $display("FAIL trunc_ferr_width: got %0d long want 0", ferr_long); else passed++;
        total++; if (obs_q.size() != 0) $display("FAIL trunc_events: got %0d want 0", obs_q.size()); else passed++;
        total++; if (spi_shift_reg !== exp_last) $display("FAIL trunc_shift: got %h want %h", spi_shift_reg, exp_last); else passed++;
        total++; if (byte_count !== CNT_W'(exp_count)) $display("FAIL trunc_count: got %0d want %0d", byte_count, exp_count); else passed++;
        tx_bytes[0] = 8'h30;
        tx_len      = 1;
        send_frame();
        got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        total++; if (got !== 8'h30) $display("FAIL trunc_next_byte: got %h want 30", got); else passed++;
        total++; if (echo_bytes[0] !== exp_last) $display("FAIL trunc_next_echo: got %h want %h", echo_bytes[0], exp_last); else passed++;
        exp_count = (exp_count + 1) % (1 << CNT_W);
        exp_last  = 8'h30;
        total++; if (byte_count !== CNT_W'(exp_count)) $display("FAIL trunc_next_count: got %0d want %0d", byte_count, exp_count); else passed++;
        $display("test_truncated: pulses %0d then rx %h count %0d", ferr_pulses, got, byte_count);
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] got;
        cs_start();
        send_bits(8'hC3, 4, echo_bytes[0]);
        apply_reset();
        send_bits(8'h3C, 4, echo_bytes[0]);
        send_bits(8'hAA, 8, echo_bytes[1]);
        total++; if (obs_q.size() != 0) $display("FAIL rst_mid_events: got %0d want 0", obs_q.size()); else passed++;
        total++; if (byte_count !== '0) $display("FAIL rst_mid_count: got %0d want 0", byte_count); else passed++;
        total++; if (spi_shift_reg !== 8'h00) $display("FAIL rst_mid_shift: got %h want 00", spi_shift_reg); else passed++;
        total++; if (spi_miso !== 1'b0) $display("FAIL rst_mid_miso: got %b want 0", spi_miso); else passed++;
        cs_end();
        total++; if (ferr_pulses != 0) $display("FAIL rst_mid_ferr: got %0d want 0", ferr_pulses); else passed++;
        tx_bytes[0] = 8'h55;
        tx_len      = 1;
        send_frame();
        got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        total++; if (got !== 8'h55) $display("FAIL rst_mid_byte: got %h want 55", got); else passed++;
        total++; if (byte_count !== CNT_W'(1)) $display("FAIL rst_mid_count2: got %0d want 1", byte_count); else passed++;
        exp_count = 1;
        exp_last  = 8'h55;
        $display("test_reset_mid_byte: rx %h count %0d", got, byte_count);
    endtask

    task automatic test_wrap();
        logic [7:0] got;
        logic [7:0] prev_last;
        int         mism;
        apply_reset();
        tx_len = (1 << CNT_W) - 1;
        for (int k = 0; k < tx_len; k++) tx_bytes[k] = 8'($urandom_range(0, 255));
        send_frame();
        mism = 0;
        for (int k = 0; k < tx_len; k++) begin
            got = (obs_q.size() > k) ? obs_q[k] : 8'hxx;
            if (got !== tx_bytes[k]) mism++;
        end
        total++; if (mism != 0 || obs_q.size() != tx_len) $display("FAIL wrap_bytes: got %0d wrong of %0d events want 0 of %0d", mism, obs_q.size(), tx_len); else passed++;
        exp_count = tx_len;
        prev_last = tx_bytes[tx_len-1];
        total++; if (byte_count !== CNT_W'(exp_count)) $display("FAIL wrap_max: got %0d want %0d", byte_count, exp_count); else passed++;
        obs_q.delete();
        tx_bytes[0] = 8'($urandom_range(0, 255));
        tx_len      = 1;
        send_frame();
        got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        exp_count = (exp_count + 1) % (1 << CNT_W);
        exp_last  = tx_bytes[0];
        total++; if (byte_count !== CNT_W'(exp_count)) $display("FAIL wrap_zero: got %0d want %0d", byte_count, exp_count); else passed++;
        total++; if (got !== tx_bytes[0]) $display("FAIL wrap_last_byte: got %h want %h", got, tx_bytes[0]); else passed++;
        total++; if (echo_bytes[0] !== prev_last) $display("FAIL wrap_echo: got %h want %h", echo_bytes[0], prev_last); else passed++;
        total++; if (ferr_pulses != 0) $display("FAIL wrap_ferr: got %0d want 0", ferr_pulses); else passed++;
        $display("test_wrap: count after %0d bytes = %0d", (1 << CNT_W), byte_count);
    endtask

    task automatic test_cs_race();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        obs_q.delete();
        ferr_pulses = 0;
        cs_start();
        send_bits(b, 7, echo_bytes[0]);
        @(negedge clk);
        spi_mosi = b[0];
        repeat (HALF) @(negedge clk);
        spi_sck  = 1'b1;
        spi_cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        total++; if (ferr_pulses != 1) $display("FAIL race_ferr: got %0d pulses want 1", ferr_pulses); else passed++;
        total++; if (obs_q.size() != 0) $display("FAIL race_events: got %0d want 0", obs_q.size()); else passed++;
        total++; if (spi_shift_reg !== exp_last) $display("FAIL race_shift: got %h want %h", spi_shift_reg, exp_last); else passed++;
        total++; if (byte_count !== CNT_W'(exp_count)) $display("FAIL race_count: got %0d want %0d", byte_count, exp_count); else passed++;
        $display("test_cs_race: tx %h discarded, pulses %0d", b, ferr_pulses);
    endtask

    task automatic test_random();
        logic [7:0] got;
        logic [7:0] exp_echo;
        for (int f = 0; f < 4; f++) begin
            obs_q.delete();
            ferr_pulses = 0;
            tx_len = $urandom_range(1, 5);
            for (int k = 0; k < tx_len; k++) tx_bytes[k] = 8'($urandom_range(0, 255));
            send_frame();
            total++; if (obs_q.size() != tx_len) $display("FAIL rand%0d_events: got %0d want %0d", f, obs_q.size(), tx_len); else passed++;
            for (int k = 0; k < tx_len; k++) begin
                got      = (obs_q.size() > k) ? obs_q[k] : 8'hxx;
                exp_echo = (k == 0) ? exp_last : tx_bytes[k-1];
                total++; if (got !== tx_bytes[k]) $display("FAIL rand%0d_byte%0d: got %h want %h", f, k, got, tx_bytes[k]); else passed++;
                total++; if (echo_bytes[k] !== exp_echo) $display("FAIL rand%0d_echo%0d: got %h want %h", f, k, echo_bytes[k], exp_echo); else passed++;
                $display("test_random: frame %0d byte %0d tx %h rx %h miso %h", f, k, tx_bytes[k], got, echo_bytes[k]);
            end
            exp_count = (exp_count + tx_len) % (1 << CNT_W);
            exp_last  = tx_bytes[tx_len-1];
            total++; if (byte_count !== CNT_W'(exp_count)) $display("FAIL rand%0d_count: got %0d want %0d", f, byte_count, exp_count); else passed++;
            total++; if (ferr_pulses != 0) $display("FAIL rand%0d_ferr: got %0d want 0", f, ferr_pulses); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_truncated();
        test_reset_mid_byte();
        test_wrap();
        test_cs_race();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
